// File: rtl/bpred_update.sv
// Branch resolution: queues in-order prediction records, resolves them against execute, drives redirect/BTB/bimodal updates.
// Latency: resolve in cycle N -> mispredict/redirect/BTB write registered in N+1; counter write lands at end of N+1; lookup 1 cycle.
// Backpressure: pred_ready drops while sweeping or when the record FIFO is full; resolves are never stalled (bad ones set err).
module bpred_update #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_CTR   = 2'b01
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pred_valid,
    output logic        pred_ready,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic [8:0]  lu_index,
    output logic [1:0]  lu_data,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        btb_wren,
    output logic [7:0]  btb_w_addr,
    output logic [31:0] btb_w_data,
    output logic        init_done,
    output logic        err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [8:0]  init_idx_q, init_idx_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        err_q, err_d;
    logic        mispredict_q, mispredict_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        btb_wren_q, btb_wren_d;
    logic [7:0]  btb_w_addr_q, btb_w_addr_d;
    logic [31:0] btb_w_data_q, btb_w_data_d;
    logic [1:0]  lu_data_q, lu_data_d;
    // counter read-modify-write pipeline: read at resolve, write one cycle later
    logic        upd_vld_q, upd_vld_d;
    logic [8:0]  upd_idx_q, upd_idx_d;
    logic        upd_taken_q, upd_taken_d;
    logic [1:0]  upd_ctr_q, upd_ctr_d;

    // record storage and bimodal table (no reset; pointers and the sweep define validity)
    logic [31:0] fifo_pc_mem [FIFO_DEPTH];
    logic        fifo_tk_mem [FIFO_DEPTH];
    logic [31:0] fifo_tg_mem [FIFO_DEPTH];
    logic [1:0]  ctr_mem     [512];

    logic        run, empty, full, push, pop, mis, btb_wr;
    logic [31:0] head_pc, head_tg;
    logic        head_tk;
    logic [8:0]  head_idx;
    logic        ctr_we;
    logic [8:0]  ctr_widx;
    logic [1:0]  ctr_wval;
    logic [1:0]  upd_next;

    assign run      = (state_q == S_RUN);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_pc  = fifo_pc_mem[rd_ptr_q[AW-1:0]];
    assign head_tk  = fifo_tk_mem[rd_ptr_q[AW-1:0]];
    assign head_tg  = fifo_tg_mem[rd_ptr_q[AW-1:0]];
    assign head_idx = head_pc[10:2];

    assign pop    = res_valid && run && !empty;
    assign mis    = pop && ((head_tk != res_taken) || (res_taken && (head_tg != res_target)));
    assign btb_wr = pop && res_taken && (head_tg != res_target);
    // full blocks a push even when a pop happens in the same cycle; a mispredict flushes it
    assign push   = pred_valid && run && !full && !mis;

    // saturating step of the counter captured at resolve time
    assign upd_next = upd_taken_q ? ((upd_ctr_q == 2'b11) ? 2'b11 : upd_ctr_q + 2'd1)
                                  : ((upd_ctr_q == 2'b00) ? 2'b00 : upd_ctr_q - 2'd1);

    // sweep sequencing: one table entry per cycle, then run forever until reset
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            S_INIT: begin
                init_idx_d = init_idx_q + 9'd1;
                if (init_idx_q == 9'd511) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // single table write port shared by the sweep and resolve updates
    always_comb begin
        ctr_we   = 1'b0;
        ctr_widx = upd_idx_q;
        ctr_wval = upd_next;
        if (!run) begin
            ctr_we   = 1'b1;
            ctr_widx = init_idx_q;
            ctr_wval = INIT_CTR;
        end else if (upd_vld_q) begin
            ctr_we = 1'b1;
        end
    end

    // resolve, FIFO pointer and output next-state logic
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        err_d         = err_q | (res_valid && !pop);
        mispredict_d  = mis;
        redirect_pc_d = redirect_pc_q;
        btb_wren_d    = btb_wr;
        btb_w_addr_d  = btb_w_addr_q;
        btb_w_data_d  = btb_w_data_q;
        upd_vld_d     = pop;
        upd_idx_d     = head_idx;
        upd_taken_d   = res_taken;
        // forward a write landing this edge so back-to-back updates chain
        upd_ctr_d     = (ctr_we && (ctr_widx == head_idx)) ? ctr_wval : ctr_mem[head_idx];
        // write-first lookup; table contents are not exposed during the sweep
        lu_data_d     = 2'b00;
        if (run) begin
            lu_data_d = (ctr_we && (ctr_widx == lu_index)) ? ctr_wval : ctr_mem[lu_index];
        end

        if (mis) begin
            redirect_pc_d = res_taken ? res_target : head_pc + 32'd4;
            // drop every younger record: queue empties next cycle
            rd_ptr_d      = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (btb_wr) begin
            btb_w_addr_d = head_pc[9:2];
            btb_w_data_d = {2'b00, res_target[31:2]};
        end
    end

    // control and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_INIT;
            init_idx_q    <= 9'd0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            err_q         <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= 32'd0;
            btb_wren_q    <= 1'b0;
            btb_w_addr_q  <= 8'd0;
            btb_w_data_q  <= 32'd0;
            lu_data_q     <= 2'b00;
            upd_vld_q     <= 1'b0;
            upd_idx_q     <= 9'd0;
            upd_taken_q   <= 1'b0;
            upd_ctr_q     <= 2'b00;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            err_q         <= err_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            btb_wren_q    <= btb_wren_d;
            btb_w_addr_q  <= btb_w_addr_d;
            btb_w_data_q  <= btb_w_data_d;
            lu_data_q     <= lu_data_d;
            upd_vld_q     <= upd_vld_d;
            upd_idx_q     <= upd_idx_d;
            upd_taken_q   <= upd_taken_d;
            upd_ctr_q     <= upd_ctr_d;
        end
    end

    // storage arrays: record push and table write
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_mem[wr_ptr_q[AW-1:0]] <= pred_pc;
            fifo_tk_mem[wr_ptr_q[AW-1:0]] <= pred_taken;
            fifo_tg_mem[wr_ptr_q[AW-1:0]] <= pred_target;
        end
        if (ctr_we) begin
            ctr_mem[ctr_widx] <= ctr_wval;
        end
    end

    assign pred_ready  = run && !full;
    assign init_done   = run;
    assign err         = err_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_pc_q;
    assign btb_wren    = btb_wren_q;
    assign btb_w_addr  = btb_w_addr_q;
    assign btb_w_data  = btb_w_data_q;
    assign lu_data     = lu_data_q;

endmodule

// File: tb/tb_bpred_update.sv
// Bench for bpred_update: directed steps then random traffic, checked against a queue/array reference model.
// Outputs sampled 1 time unit after each rising edge; inputs driven at that same point.
// Every comparison is an immediate assertion that counts failures.
module tb_bpred_update;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pred_valid = 1'b0;
    logic        pred_ready;
    logic [31:0] pred_pc = '0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = '0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic [8:0]  lu_index = '0;
    logic [1:0]  lu_data;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        btb_wren;
    logic [7:0]  btb_w_addr;
    logic [31:0] btb_w_data;
    logic        init_done;
    logic        err;

    bpred_update #(.FIFO_DEPTH(DEPTH), .INIT_CTR(2'b01)) dut (
        .clk(clk), .reset_n(reset_n),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .lu_index(lu_index), .lu_data(lu_data),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .btb_wren(btb_wren), .btb_w_addr(btb_w_addr), .btb_w_data(btb_w_data),
        .init_done(init_done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tg;
    } rec_t;
    rec_t        q[$];
    int          ctr[512];
    int          init_cnt;
    bit          m_err;
    bit          pend_v;
    int          pend_idx;
    bit          pend_tk;
    bit          e_mis, e_wren;
    logic [31:0] e_redir, e_wdata;
    logic [7:0]  e_waddr;
    int          e_lu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 512; i++) ctr[i] = 1;
        init_cnt = 0;
        m_err    = 0;
        pend_v   = 0;
    endtask

    task automatic set_idle();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    // one clock: predict from current inputs, advance, compare all outputs
    task automatic tick();
        bit   run;
        bit   mis;
        bit   wr;
        int   sz;
        rec_t h;
        rec_t n;
        run = (init_cnt >= 512);
        mis = 0;
        wr  = 0;
        if (pend_v) begin
            if (pend_tk) ctr[pend_idx] = (ctr[pend_idx] >= 3) ? 3 : ctr[pend_idx] + 1;
            else         ctr[pend_idx] = (ctr[pend_idx] <= 0) ? 0 : ctr[pend_idx] - 1;
            pend_v = 0;
        end
        e_lu = run ? ctr[lu_index] : 0;
        sz = q.size();
        if (res_valid) begin
            if (run && sz > 0) begin
                h = q.pop_front();
                mis = (h.tk != res_taken) || (res_taken && h.tg != res_target);
                wr  = res_taken && (h.tg != res_target);
                pend_v = 1; pend_idx = int'(h.pc[10:2]); pend_tk = res_taken;
                if (mis) begin
                    e_redir = res_taken ? res_target : h.pc + 32'd4;
                    q.delete();
                end
                if (wr) begin
                    e_waddr = h.pc[9:2];
                    e_wdata = res_target >> 2;
                end
            end else begin
                m_err = 1;
            end
        end
        if (pred_valid && run && sz < DEPTH && !mis) begin
            n.pc = pred_pc; n.tk = pred_taken; n.tg = pred_target;
            q.push_back(n);
        end
        e_mis  = mis;
        e_wren = wr;
        if (!run) init_cnt++;
        @(posedge clk);
        #1;
        chk("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
        if (e_mis) chk("redirect_pc", redirect_pc, e_redir);
        chk("btb_wren", {31'd0, btb_wren}, {31'd0, e_wren});
        if (e_wren) begin
            chk("btb_w_addr", {24'd0, btb_w_addr}, {24'd0, e_waddr});
            chk("btb_w_data", btb_w_data, e_wdata);
        end
        chk("lu_data", {30'd0, lu_data}, e_lu);
        chk("init_done", {31'd0, init_done}, {31'd0, init_cnt >= 512});
        chk("pred_ready", {31'd0, pred_ready}, {31'd0, (init_cnt >= 512) && (q.size() < DEPTH)});
        chk("err", {31'd0, err}, {31'd0, m_err});
    endtask

    // async reset: outputs must clear without a clock edge
    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_btb_wren", {31'd0, btb_wren}, 32'd0);
        chk("rst_btb_addr", {24'd0, btb_w_addr}, 32'd0);
        chk("rst_btb_data", btb_w_data, 32'd0);
        chk("rst_lu_data", {30'd0, lu_data}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_pred_ready", {31'd0, pred_ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tg;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tg);
        res_valid = 1'b1; res_taken = tk; res_target = tg;
    endtask

    initial begin
        // reset state and first sweep
        #3;
        do_reset();
        for (int i = 0; i < 512; i++) begin
            lu_index = 9'($urandom_range(0, 511));
            tick();
        end
        chk("sweep_done", {31'd0, init_done}, 32'd1);
        lu_index = 9'd0;   tick();
        chk("lu_0", {30'd0, lu_data}, 32'd1);
        lu_index = 9'd255; tick();
        chk("lu_255", {30'd0, lu_data}, 32'd1);
        lu_index = 9'd511; tick();
        chk("lu_511", {30'd0, lu_data}, 32'd1);

        // predicted not-taken, actually taken: redirect + BTB write + counter up
        set_idle(); push(32'h100, 1'b0, 32'h0); tick();
        set_idle(); resolve(1'b1, 32'h200); tick();
        chk("tp1_mis", {31'd0, mispredict}, 32'd1);
        chk("tp1_redir", redirect_pc, 32'h200);
        chk("tp1_wren", {31'd0, btb_wren}, 32'd1);
        chk("tp1_addr", {24'd0, btb_w_addr}, 32'h40);
        chk("tp1_data", btb_w_data, 32'h80);
        set_idle(); lu_index = 9'h40; tick(); tick();
        chk("tp1_ctr", {30'd0, lu_data}, 32'd2);

        // predicted taken, actually not-taken; then saturate at 0
        set_idle(); push(32'h104, 1'b1, 32'h300); tick();
        set_idle(); resolve(1'b0, 32'h0); tick();
        chk("tp2_mis", {31'd0, mispredict}, 32'd1);
        chk("tp2_redir", redirect_pc, 32'h108);
        chk("tp2_wren", {31'd0, btb_wren}, 32'd0);
        for (int i = 0; i < 3; i++) begin set_idle(); push(32'h104, 1'b0, 32'h0); tick(); end
        for (int i = 0; i < 3; i++) begin set_idle(); resolve(1'b0, 32'h0); tick(); end
        set_idle(); lu_index = 9'h41; tick(); tick();
        chk("tp2_ctr", {30'd0, lu_data}, 32'd0);

        // fill, refuse, push+pop at occupancy 2, flush with concurrent push
        for (int i = 0; i < 4; i++) begin set_idle(); push(32'h200 + 32'(4 * i), 1'b0, 32'h0); tick(); end
        chk("full_ready", {31'd0, pred_ready}, 32'd0);
        set_idle(); push(32'h500, 1'b0, 32'h0); tick();
        for (int i = 0; i < 2; i++) begin set_idle(); resolve(1'b0, 32'h0); tick(); end
        set_idle(); push(32'h600, 1'b0, 32'h0); resolve(1'b0, 32'h0); tick();
        set_idle(); push(32'h604, 1'b0, 32'h0); tick();
        set_idle(); push(32'h608, 1'b0, 32'h0); resolve(1'b1, 32'h700); tick();
        chk("flush_mis", {31'd0, mispredict}, 32'd1);
        set_idle(); tick();
        chk("flush_ready", {31'd0, pred_ready}, 32'd1);

        // resolve with nothing outstanding
        set_idle(); resolve(1'b1, 32'h900); tick();
        chk("empty_err", {31'd0, err}, 32'd1);
        chk("empty_mis", {31'd0, mispredict}, 32'd0);
        set_idle(); tick(); tick(); tick();
        chk("err_sticky", {31'd0, err}, 32'd1);

        // reset mid-sweep, full sweep again
        do_reset();
        for (int i = 0; i < 200; i++) begin lu_index = 9'($urandom_range(0, 511)); tick(); end
        do_reset();
        for (int i = 0; i < 511; i++) begin lu_index = 9'($urandom_range(0, 511)); tick(); end
        chk("resweep_not_done", {31'd0, init_done}, 32'd0);
        tick();
        chk("resweep_done", {31'd0, init_done}, 32'd1);

        // random traffic with heavy index and target aliasing
        for (int i = 0; i < 3000; i++) begin
            set_idle();
            if ($urandom_range(0, 1) == 1) begin
                pred_valid  = 1'b1;
                pred_pc     = $urandom & 32'hFFFF_F01C;
                if ($urandom_range(0, 15) == 0) pred_pc = 32'hFFFF_FFFC;
                pred_taken  = 1'($urandom_range(0, 1));
                pred_target = 32'h8000 | (32'($urandom_range(0, 3)) << 4);
            end
            if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
                res_valid  = 1'b1;
                res_taken  = 1'($urandom_range(0, 1));
                res_target = ($urandom_range(0, 1) == 1) ? q[0].tg
                                                         : 32'h8000 | (32'($urandom_range(0, 3)) << 4);
            end
            lu_index = 9'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) lu_index = 9'd511;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
